// File: rtl/debounce_pkg.sv
// Shared types and default constants for the push-button debouncer.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } debounce_state_t;

    // 10 ms at 100 MHz
    localparam int unsigned DEBOUNCE_STABLE_CYCLES_DEFAULT = 1000000;
    localparam int unsigned DEBOUNCE_SYNC_STAGES_DEFAULT   = 2;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a single asynchronous input; clears to 0 on reset.
module sync_chain #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    if (SYNC_STAGES < 2) begin : g_bad_stages
        $error("sync_chain: SYNC_STAGES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] stages_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stages_q <= '0;
        end else begin
            stages_q <= {stages_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = stages_q[SYNC_STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Synchronizes a bouncing button and only moves level_out after a stable run of samples.
// Define BUTTON_DEBOUNCER_ACTIVE_LOW_EN for pull-up buttons (pin reads 0 when pressed).
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEBOUNCE_STABLE_CYCLES_DEFAULT,
    parameter int unsigned SYNC_STAGES   = DEBOUNCE_SYNC_STAGES_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic button_in,
    output logic level_out,
    output logic busy
);

    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $error("button_debouncer: STABLE_CYCLES must be at least 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("button_debouncer: SYNC_STAGES must be at least 2");
    end

    localparam int unsigned    CntW    = $clog2(STABLE_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    logic pin;
    logic sync_q;

`ifdef BUTTON_DEBOUNCER_ACTIVE_LOW_EN
    assign pin = ~button_in;
`else
    assign pin = button_in;
`endif

    sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i (clock),
        .rst_ni(reset),
        .d_i   (pin),
        .q_o   (sync_q)
    );

    debounce_state_t state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            busy_q, busy_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            busy_q  <= busy_d;
        end
    end

    // Counter is cleared on every exit from a WAIT state, so it never reaches STABLE_CYCLES.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            IDLE_LOW: begin
                if (sync_q) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = CntOne;
                end
            end
            WAIT_HIGH: begin
                if (!sync_q) begin
                    state_d = IDLE_LOW;
                end else if (cnt_q == CntLast) begin
                    state_d = IDLE_HIGH;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            IDLE_HIGH: begin
                if (!sync_q) begin
                    state_d = WAIT_LOW;
                    cnt_d   = CntOne;
                end
            end
            WAIT_LOW: begin
                if (sync_q) begin
                    state_d = IDLE_HIGH;
                end else if (cnt_q == CntLast) begin
                    state_d = IDLE_LOW;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: state_d = IDLE_LOW;
        endcase
    end

    // Outputs are decoded from the next state and registered, so both are glitch-free flops.
    always_comb begin
        level_d = (state_d == IDLE_HIGH) || (state_d == WAIT_LOW);
        busy_d  = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
    end

    assign level_out = level_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Randomized and directed bench for button_debouncer against a run-length reference model.
module tb_button_debouncer;

    localparam int unsigned StableCycles = 4;
    localparam int unsigned SyncStages   = 2;
`ifdef BUTTON_DEBOUNCER_ACTIVE_LOW_EN
    localparam bit Inv = 1'b1;
`else
    localparam bit Inv = 1'b0;
`endif

    logic clock;
    logic reset;
    logic button_in;
    logic level_out;
    logic busy;

    int checks = 0;
    int errors = 0;

    button_debouncer #(
        .STABLE_CYCLES(StableCycles),
        .SYNC_STAGES  (SyncStages)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .button_in(button_in),
        .level_out(level_out),
        .busy     (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int dut_rises = 0;
    always @(posedge level_out) dut_rises++;

    // Reference: level follows "pressed" once it has been seen, after the synchronizer
    // delay, for StableCycles consecutive samples that disagree with the current level.
    bit hist[$];
    bit m_level;
    int m_run;
    int m_rises;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < int'(SyncStages); i++) hist.push_back(1'b0);
        m_level = 1'b0;
        m_run   = 0;
    endtask

    // Called at negedge; returns at the next negedge.
    task automatic step(input string tag);
        bit s;
        @(posedge clock);
        hist.push_back(button_in ^ Inv);
        s = hist.pop_front();
        if (s != m_level) begin
            m_run++;
            if (m_run == int'(StableCycles)) begin
                m_level = s;
                m_run   = 0;
                if (s) m_rises++;
            end
        end else begin
            m_run = 0;
        end
        #1;
        check_val({tag, ".level"}, 32'(level_out), 32'(m_level));
        check_val({tag, ".busy"}, 32'(busy), 32'(m_run > 0));
        @(negedge clock);
    endtask

    // v is the "pressed" value; the pin polarity follows the build.
    task automatic drive(input bit v, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            button_in = v ^ Inv;
            step(tag);
        end
    endtask

    int r0;
    int d0;

    initial begin
        m_rises   = 0;
        reset     = 1'b0;
        button_in = Inv;
        model_reset();
        #1;
        check_val("reset.level", 32'(level_out), 32'd0);
        check_val("reset.busy", 32'(busy), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        drive(1'b0, 6, "idle");

        // Clean press: rise lands on the 6th edge, one downstream edge.
        r0 = dut_rises;
        drive(1'b1, 5, "press_pre");
        check_val("press.before_edge6", 32'(level_out), 32'd0);
        drive(1'b1, 1, "press_edge6");
        check_val("press.at_edge6", 32'(level_out), 32'd1);
        drive(1'b1, 6, "press_hold");
        check_val("press.one_edge", 32'(dut_rises - r0), 32'd1);

        // Release and low glitch while high.
        drive(1'b0, 12, "release");
        drive(1'b1, 12, "repress");
        drive(1'b0, 3, "low_glitch");
        drive(1'b1, 8, "after_glitch");
        check_val("low_glitch.held", 32'(level_out), 32'd1);

        // Bounce rejection and short pulse from low.
        drive(1'b0, 12, "to_low");
        drive(1'b1, 1, "bounce");
        drive(1'b0, 1, "bounce");
        drive(1'b1, 1, "bounce");
        drive(1'b0, 1, "bounce");
        drive(1'b1, 10, "settle");
        drive(1'b0, 12, "to_low2");
        drive(1'b1, 3, "hi_pulse");
        drive(1'b0, 8, "after_pulse");
        check_val("hi_pulse.rejected", 32'(level_out), 32'd0);

        // Reset in the middle of WAIT_HIGH.
        drive(1'b1, 3, "pre_reset");
        #2 reset = 1'b0;
        #1;
        check_val("mid_wait_reset.level", 32'(level_out), 32'd0);
        check_val("mid_wait_reset.busy", 32'(busy), 32'd0);
        @(negedge clock);
        check_val("in_reset.level", 32'(level_out), 32'd0);
        reset = 1'b1;
        model_reset();
        drive(1'b1, 10, "post_reset");

        // Reset while high forces level low.
        #2 reset = 1'b0;
        #1;
        check_val("high_reset.level", 32'(level_out), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        drive(1'b0, 8, "post_reset2");

        // Sustained hold.
        drive(1'b0, 10, "pre_hold");
        r0 = m_rises;
        d0 = dut_rises;
        drive(1'b1, 1000, "hold");
        check_val("hold.model_one_rise", 32'(m_rises - r0), 32'd1);
        check_val("hold.dut_rises", 32'(dut_rises - d0), 32'(m_rises - r0));

        // Random runs of varying length around the qualification threshold.
        r0 = m_rises;
        d0 = dut_rises;
        for (int k = 0; k < 300; k++) begin
            drive(1'($urandom & 1), int'($urandom_range(1, 7)), "rand");
        end
        check_val("rand.rises", 32'(dut_rises - d0), 32'(m_rises - r0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Conditions a raw, asynchronous push-button or switch input into a clean, glitch-free level in the system clock domain.
- Sits directly upstream of the rising-edge detector. Its `level_out` drives that detector's input, so one physical press yields exactly one detected edge.
- Operation: synchronizer chain, then a stability-counting FSM. The output changes only after the synchronized input has held a new value for a programmable number of cycles.

Parameters:
- STABLE_CYCLES, default 1000000: consecutive synchronized samples required before the output changes. This is 10 ms at 100 MHz. Legal range is 2 or more; elaboration-time assertion.
- SYNC_STAGES, default 2: flip-flops in the synchronizer chain. Legal range is 2 or more; elaboration-time assertion.

Ports:
- clock, input, 1: system clock; all flops on posedge.
- reset, input, 1: asynchronous, active-low reset. Asserted when 0; all flops clear immediately on negedge reset.
- button_in, input, 1: raw, asynchronous, bouncing input.
- level_out, output, 1: debounced level; drives the edge detector's input.
- busy, output, 1: high while a candidate transition is being qualified (FSM in a WAIT state).

Behaviour:
- Reset values: synchronizer flops 0, counter 0, state IDLE_LOW, `level_out` 0, `busy` 0.
- Synchronizer: `button_in` passes through SYNC_STAGES flops; the last stage is `sync_q`. The FSM reads only `sync_q`.
- Counter width is $clog2(STABLE_CYCLES) bits. The counter never wraps: it is cleared before reaching STABLE_CYCLES.
- States and transitions (all registered):
  - IDLE_LOW (`level_out` 0): if `sync_q`==1, go to WAIT_HIGH with count=1; else stay, count=0.
  - WAIT_HIGH:
    - If `sync_q`==0: return to IDLE_LOW, count=0 (bounce rejected).
    - Else if count==STABLE_CYCLES-1: go to IDLE_HIGH, `level_out`=1, count=0.
    - Else: count+1.
  - IDLE_HIGH (`level_out` 1): if `sync_q`==0, go to WAIT_LOW with count=1; else stay.
  - WAIT_LOW: mirror of WAIT_HIGH with the polarities swapped. On completion go to IDLE_LOW, `level_out`=0.
- `busy` = registered (state is WAIT_HIGH or WAIT_LOW).
- `level_out` is a registered flop output, never combinational, so the edge detector always sees a clean level.
- Latency: a stable change on `button_in`, set up before edge 1, appears on `level_out` after edge SYNC_STAGES+STABLE_CYCLES. `level_out` toggles at most once per STABLE_CYCLES cycles.
- Any disagreeing sample in a WAIT state restarts qualification from the IDLE state. The output never changes on a pulse shorter than STABLE_CYCLES samples.
- Reset mid-WAIT aborts the qualification: all state returns to reset values, and `level_out` goes 0 even if it was 1.
- Input held high across reset release: after release the FSM qualifies it normally. `level_out` rises SYNC_STAGES+STABLE_CYCLES edges later, producing one edge downstream.

Optional Feature:
- Macro: BUTTON_DEBOUNCER_ACTIVE_LOW_EN.
- Defined: `button_in` is inverted before the first synchronizer stage, for pull-up buttons that read 0 when pressed. `level_out` is 1 while pressed. Reset values are unchanged, so an idle (high) pin reads as not pressed with no spurious edge after reset.
- Undefined: `button_in` is used as-is (active-high).

Decomposition:
- Package `debounce_pkg`: enum typedef `debounce_state_t` {IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW}, plus the default constants DEBOUNCE_STABLE_CYCLES_DEFAULT and DEBOUNCE_SYNC_STAGES_DEFAULT.
- One sub-module, `sync_chain`: parameterized SYNC_STAGES-deep flop chain with active-low asynchronous reset clearing to 0. It is reusable for other asynchronous inputs.

Test Plan (STABLE_CYCLES=4, SYNC_STAGES=2 unless noted):
- Clean press: drive `button_in` 0→1 and hold. `level_out` rises at edge 6 after the change. `busy` is high for the edges in WAIT_HIGH and drops with the `level_out` rise. The downstream edge detector fires exactly once.
- Bounce rejection: drive 1,0,1,0 on successive cycles, then settle at 1. `level_out` stays 0 through the bounces, then rises 6 edges after the final 0→1. A 3-cycle high pulse never raises `level_out`.
- Release: from IDLE_HIGH, drive 1→0 and hold. `level_out` falls at edge 6. A 3-cycle low glitch while high leaves `level_out` at 1.
- Reset mid-operation: assert reset (0) during WAIT_HIGH, then release. All outputs are immediately 0 and the counter restarts. With input held 1, `level_out` rises 6 edges after release.
- Sustained hold: hold input 1 for 1000 cycles. Exactly one `level_out` transition occurs, with no wrap artefacts and `busy` low after qualification.
- With BUTTON_DEBOUNCER_ACTIVE_LOW_EN defined: idle pin at 1 gives `level_out` 0. Drive the pin 1→0 and `level_out` rises at edge 6.
